ah_lru_client_8: RTL and testbench

AH_LRU_CLIENT_8 -- requirements
Module: ah_lru_client_8

---
 rtl/ah_lru_client_8.sv | 140 ++++++++++++++
 tb/tb_ah_lru_client_8.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ah_lru_client_8.sv
// ah_lru_client_8: per-channel client front end for an LRU arbiter.
// Each channel queues pushed transactions in a saturating pending counter.
// It raises req while it has work and, once granted, holds gnt_busy for
// XFER_LEN cycles, pulsing done in the last of them.
// Grants that are not one-hot, or that land on a channel not requesting,
// are rejected and latched into the sticky err flag.
module ah_lru_client_8 #(
    parameter int N        = 8,
    parameter int CNT_W    = 4,
    parameter int XFER_LEN = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] push,
    input  logic [N-1:0] gnt,
    input  logic         err_clr,
    output logic [N-1:0] req,
    output logic [N-1:0] gnt_busy,
    output logic [N-1:0] done,
    output logic [N-1:0] full,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] PEND_MAX  = '1;
    localparam logic [CNT_W-1:0] PEND_ONE  = 1;
    localparam logic [7:0]       XFER_LOAD = 8'(XFER_LEN - 1);
    localparam logic [7:0]       XCNT_ONE  = 8'd1;
    localparam logic [N-1:0]     GNT_ONE   = 1;

    logic         gntOneHot;
    logic         gntMulti;
    logic [N-1:0] strayGnt;
    logic         violation;
    logic         err_q;
    logic         err_d;

    // A grant is only usable when exactly one bit is set.
    assign gntOneHot = (gnt != '0) && ((gnt & (gnt - GNT_ONE)) == '0);
    assign gntMulti  = (gnt != '0) && !gntOneHot;
    assign violation = gntMulti || (|strayGnt);
    assign err       = err_q;

    for (genvar i = 0; i < N; i++) begin : gChan
        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] pendCnt_q;
        logic [CNT_W-1:0] pendCnt_d;
        logic [7:0]       xferCnt_q;
        logic [7:0]       xferCnt_d;
        logic             accept;
        logic             isFull;

        // Only a requesting channel may take a clean one-hot grant; any other
        // grant bit aimed at this channel counts as a protocol violation.
        assign isFull      = (pendCnt_q == PEND_MAX);
        assign accept      = gnt[i] && (state_q == REQ) && gntOneHot;
        assign strayGnt[i] = gnt[i] && (state_q != REQ);

        assign req[i]      = (state_q == REQ);
        assign gnt_busy[i] = (state_q == XFER);
        assign done[i]     = (state_q == XFER) && (xferCnt_q == '0);
        assign full[i]     = isFull;

        // Channel state, pending queue depth and transfer countdown registers.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q   <= IDLE;
                pendCnt_q <= '0;
                xferCnt_q <= '0;
            end else begin
                state_q   <= state_d;
                pendCnt_q <= pendCnt_d;
                xferCnt_q <= xferCnt_d;
            end
        end

        // Next-state, pending bookkeeping and transfer countdown for one channel.
        always_comb begin
            state_d   = state_q;
            pendCnt_d = pendCnt_q;
            xferCnt_d = xferCnt_q;

            if (accept && !push[i]) begin
                pendCnt_d = pendCnt_q - PEND_ONE;
            end else if (push[i] && !accept && !isFull) begin
                pendCnt_d = pendCnt_q + PEND_ONE;
            end

            unique case (state_q)
                IDLE: begin
                    if (pendCnt_q != '0) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (accept) begin
                        state_d   = XFER;
                        xferCnt_d = XFER_LOAD;
                    end
                end
                XFER: begin
                    if (xferCnt_q == '0) begin
                        state_d = (pendCnt_q != '0) ? REQ : IDLE;
                    end else begin
                        xferCnt_d = xferCnt_q - XCNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sticky error: a fresh violation outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (violation) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_ah_lru_client_8.sv
// tb_ah_lru_client_8: directed bench for ah_lru_client_8 (defaults N=8, CNT_W=4, XFER_LEN=4).
module tb_ah_lru_client_8;

    logic       clk;
    logic       rstn;
    logic [7:0] push;
    logic [7:0] gnt;
    logic       err_clr;
    logic [7:0] req;
    logic [7:0] gnt_busy;
    logic [7:0] done;
    logic [7:0] full;
    logic       err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] push;
        logic [7:0] gnt;
        logic       errClr;
        logic [7:0] expReq;
        logic [7:0] expBusy;
        logic [7:0] expDone;
        logic [7:0] expFull;
        logic       expErr;
    } vec_t;

    vec_t vecs [11];

    ah_lru_client_8 dut (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .gnt      (gnt),
        .err_clr  (err_clr),
        .req      (req),
        .gnt_busy (gnt_busy),
        .done     (done),
        .full     (full),
        .err      (err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] p, input logic [7:0] g, input logic c);
        push    = p;
        gnt     = g;
        err_clr = c;
        tick();
    endtask

    function automatic logic [39:0] allOuts();
        return {7'b0, req, gnt_busy, done, full, err};
    endfunction

    task automatic doReset();
        push    = '0;
        gnt     = '0;
        err_clr = 1'b0;
        rstn    = 1'b0;
        tick();
        tick();
        checkOutput("reset_outputs", allOuts(), 40'h0);
        rstn = 1'b1;
    endtask

    task automatic waitReq(input int ch);
        int n;
        n = 0;
        while (req[ch] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (req[ch] !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_req ch%0d: req=%b after %0d cycles, expected 1", ch, req[ch], n);
        end
    endtask

    initial begin
        int doneCount;
        logic sawBad;
        bit finished;

        rstn    = 1'b0;
        push    = '0;
        gnt     = '0;
        err_clr = 1'b0;

        // push, gnt, errClr | req, busy, done, full, err
        vecs[0]  = '{8'h01, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{8'h00, 8'h00, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{8'h00, 8'h01, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h01, 8'h01, 8'h00, 1'b0};
        vecs[6]  = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{8'h00, 8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[8]  = '{8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{8'h00, 8'h04, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

        // Single transfer on ch0, then stray grants and the error clear.
        doReset();
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].push, vecs[k].gnt, vecs[k].errClr);
            checkOutput($sformatf("vec%0d", k), allOuts(),
                        {7'b0, vecs[k].expReq, vecs[k].expBusy, vecs[k].expDone,
                         vecs[k].expFull, vecs[k].expErr});
        end
        err_clr = 1'b0;

        // Three queued transfers on ch3 run back to back.
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(8'h08, 8'h00, 1'b0);
        push = '0;
        for (int n = 0; n < 3; n++) begin
            waitReq(3);
            applyStimulus(8'h00, 8'h08, 1'b0);
            gnt = '0;
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("b2b_x%0d_c%0d", n, k), {38'b0, gnt_busy[3], done[3]},
                            {38'b0, 1'b1, (k == 3)});
                if (k < 3) tick();
            end
            tick();
            checkOutput($sformatf("b2b_after%0d", n), {39'b0, req[3]}, {39'b0, (n < 2)});
        end
        for (int k = 0; k < 3; k++) tick();
        checkOutput("b2b_drained", allOuts(), 40'h0);

        // Saturate ch5 with 16 pushes, then push on the granting edge while full.
        doReset();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(8'h20, 8'h00, 1'b0);
            if (k == 13) checkOutput("sat_full_at14", {39'b0, full[5]}, 40'h0);
            if (k == 14) checkOutput("sat_full_at15", {39'b0, full[5]}, 40'h1);
        end
        checkOutput("sat_full_err", {38'b0, full[5], err}, {38'b0, 1'b1, 1'b0});
        applyStimulus(8'h20, 8'h20, 1'b0);
        checkOutput("sat_push_gnt", {38'b0, full[5], gnt_busy[5]}, {38'b0, 1'b1, 1'b1});
        push = '0;
        gnt = '0;
        doneCount = 0;
        finished = 1'b0;
        for (int c = 0; c < 200 && !finished; c++) begin
            gnt = req[5] ? 8'h20 : 8'h00;
            tick();
            gnt = '0;
            if (done[5]) doneCount++;
            if (!req[5] && !gnt_busy[5]) finished = 1'b1;
        end
        checkOutput("sat_drain_done", {39'b0, finished}, 40'h1);
        checkOutput("sat_done_count", 40'(doneCount), 40'd16);
        checkOutput("sat_err_end", {39'b0, err}, 40'h0);

        // Two-hot grant with ch0 and ch1 requesting.
        doReset();
        applyStimulus(8'h03, 8'h00, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0);
        checkOutput("multi_req", {32'b0, req}, {32'b0, 8'h03});
        applyStimulus(8'h00, 8'h03, 1'b0);
        checkOutput("multi_err", {23'b0, req, gnt_busy, err}, {23'b0, 8'h03, 8'h00, 1'b1});
        applyStimulus(8'h00, 8'h00, 1'b1);
        checkOutput("multi_clr", {31'b0, req, err}, {31'b0, 8'h03, 1'b0});
        applyStimulus(8'h00, 8'h01, 1'b0);
        checkOutput("multi_then_gnt0", {32'b0, gnt_busy}, {32'b0, 8'h01});
        gnt = '0;
        for (int k = 0; k < 4; k++) tick();
        checkOutput("multi_after_xfer", {32'b0, req}, {32'b0, 8'h02});

        // Reset in the middle of a ch2 transfer with two more queued.
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(8'h04, 8'h00, 1'b0);
        push = '0;
        waitReq(2);
        applyStimulus(8'h00, 8'h04, 1'b0);
        gnt = '0;
        tick();
        checkOutput("mid_busy", {39'b0, gnt_busy[2]}, 40'h1);
        rstn = 1'b0;
        #1;
        checkOutput("mid_reset_outs", allOuts(), 40'h0);
        sawBad = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (done != '0) sawBad = 1'b1;
        end
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (req[2] || done[2] || gnt_busy[2]) sawBad = 1'b1;
        end
        checkOutput("mid_no_resume", {39'b0, sawBad}, 40'h0);
        applyStimulus(8'h01, 8'h00, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0);
        checkOutput("first_push_after_rst", {32'b0, req}, {32'b0, 8'h01});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
